seq_decoder: RTL

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_pkg.sv | 27 ++
 rtl/onehot_enc.sv | 25 ++
 rtl/seq_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg : shared one-hot vector constants, lock states and error codes.
// Rev 1.0
`default_nettype none

package seq_pkg;

  localparam logic [3:0] VEC_S0 = 4'b0001;
  localparam logic [3:0] VEC_S1 = 4'b0010;
  localparam logic [3:0] VEC_S2 = 4'b0100;
  localparam logic [3:0] VEC_S3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQ      = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NOT_ONEHOT = 2'd1,
    ERR_ILLEGAL    = 2'd2,
    ERR_HOLD       = 2'd3
  } err_code_t;

endpackage

`default_nettype wire

// File: rtl/onehot_enc.sv
// onehot_enc : 4->2 one-hot encoder with a validity flag.
// Rev 1.0
`default_nettype none

module onehot_enc (
  input  logic [3:0] i_vec,
  output logic [1:0] o_idx,
  output logic       o_onehot
);

  always_comb begin
    o_idx    = 2'd0;
    o_onehot = 1'b1;
    case (i_vec)
      4'b0001: o_idx = 2'd0;
      4'b0010: o_idx = 2'd1;
      4'b0100: o_idx = 2'd2;
      4'b1000: o_idx = 2'd3;
      default: o_onehot = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_decoder.sv
// seq_decoder : tracks a one-hot sequence generator, reports lock, mode, errors, frames.
// Rev 1.0
`default_nettype none

module seq_decoder
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] vector,
  input  logic       clr,
  output logic       locked,
  output logic [1:0] state_idx,
  output logic       mode_det,
  output logic       mode_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt,
  output logic [7:0] frame_cnt
);

  lock_state_t r_state;
  logic [3:0]  r_vec_q;
  logic        r_run_q;

  logic [1:0]  w_new_idx;
  logic        w_new_oh;
  logic [1:0]  w_old_idx;
  logic        w_old_oh;
  logic        w_legal;
  err_code_t   w_code;
  logic        w_pass;
  logic        w_frame;

  onehot_enc u_enc_new (
    .i_vec    (vector),
    .o_idx    (w_new_idx),
    .o_onehot (w_new_oh)
  );

  onehot_enc u_enc_old (
    .i_vec    (r_vec_q),
    .o_idx    (w_old_idx),
    .o_onehot (w_old_oh)
  );

  always_comb begin
    w_legal = 1'b0;
    if (w_old_oh && w_new_oh) begin
      case (w_old_idx)
        2'd0:    w_legal = (w_new_idx == 2'd1);
        2'd1:    w_legal = (w_new_idx == 2'd2) || (w_new_idx == 2'd3);
        2'd2:    w_legal = (w_new_idx == 2'd3);
        default: w_legal = (w_new_idx == 2'd0);
      endcase
    end
  end

  always_comb begin
    w_code = ERR_NONE;
    if (!w_new_oh)
      w_code = ERR_NOT_ONEHOT;
    else if (!r_run_q && (vector != r_vec_q))
      w_code = ERR_HOLD;
    else if (r_run_q && !w_legal)
      w_code = ERR_ILLEGAL;
  end

  assign w_pass  = (w_code == ERR_NONE);
  assign w_frame = (r_state == ST_LOCKED) && w_pass && r_run_q &&
                   (r_vec_q == VEC_S3) && (vector == VEC_S0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOCKED;
      r_vec_q    <= 4'd0;
      r_run_q    <= 1'b0;
      locked     <= 1'b0;
      state_idx  <= 2'd0;
      mode_det   <= 1'b0;
      mode_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      err_cnt    <= 8'd0;
      frame_cnt  <= 8'd0;
    end else begin
      r_vec_q   <= vector;
      r_run_q   <= run;
      state_idx <= w_new_idx;
      err       <= 1'b0;

      case (r_state)
        ST_UNLOCKED: begin
          if (w_new_oh)
            r_state <= ST_ACQ;
        end
        ST_ACQ: begin
          // Acquisition failures are silent; only a held lock reports errors.
          if (w_pass) begin
            r_state <= ST_LOCKED;
            locked  <= 1'b1;
          end else begin
            r_state <= ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_pass) begin
            if (r_run_q && (r_vec_q == VEC_S1)) begin
              mode_det   <= (vector == VEC_S2);
              mode_valid <= 1'b1;
            end
          end else begin
            err        <= 1'b1;
            err_code   <= w_code;
            locked     <= 1'b0;
            mode_valid <= 1'b0;
            r_state    <= w_new_oh ? ST_ACQ : ST_UNLOCKED;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_UNLOCKED;
          locked  <= 1'b0;
        end
      endcase

      if (w_frame)
        frame_cnt <= frame_cnt + 8'd1;

      // Clear wins over any increment made in the same cycle.
      if (clr) begin
        err_cnt   <= 8'd0;
        frame_cnt <= 8'd0;
      end
    end
  end

endmodule

`default_nettype wire
